uart_tx: RTL

Serial transmitter that drains a fifo instance (AWIDTH/DWIDTH style buffer with push/pop/out/empty) and emits asynchronous 8N1-style frames on a single TX line. It is the consumer stage directly downstream of the FIFO. It reads the FIFO's combinational head-of-queue data, pops one word per frame, and serializes it LSB first. Frame format (data width, parity, stop bits) and baud divisor are compile-time parameters.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_gen.sv | 40 ++++
 rtl/uart_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks.
//   uart_state_e    - transmitter FSM state encoding
//   PAR_NONE/EVEN/ODD - parity-mode selector values
//   CLKDIV_DEFAULT  - clk cycles per bit for 50 MHz / 115200 baud
//   parity_bit()    - parity of a data word for a given mode
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned CLKDIV_DEFAULT = 434;

    // Data narrower than 9 bits is zero-extended by the caller, which does
    // not change the XOR reduction.
    function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
        logic p;
        p = ^data;
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: reloadable bit-period down-counter.
//   clk_i   - system clock
//   rst_i   - asynchronous active-high reset (counter cleared to 0)
//   reload  - load CLKDIV-1 on the next edge (start of a new bit)
//   bit_end - high while the count is 0, i.e. in the last cycle of a bit
module uart_baud_gen #(
    parameter int unsigned CLKDIV = 434
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic reload,
    output logic bit_end
);

    localparam int unsigned CW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0] RELOAD_VAL = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = RELOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter draining a FIFO, LSB-first async frames.
//   clk_i      - system clock
//   rst_i      - asynchronous active-high reset
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO head word (valid while !fifo_empty)
//   fifo_pop   - one-cycle pop strobe, one per frame
//   txd        - serial line, idle high (registered)
//   busy       - high while a frame is in progress (registered)
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned CLKDIV   = CLKDIV_DEFAULT,
    parameter int unsigned PARITY   = PAR_NONE,
    parameter int unsigned STOPBITS = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              txd,
    output logic              busy
);

    localparam logic [3:0] LAST_DATA = 4'(DWIDTH - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOPBITS - 1);

    uart_state_e       state_q, state_d;
    logic [DWIDTH-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              reload;
    logic              bit_end;
    logic              last_stop;

    uart_baud_gen #(
        .CLKDIV(CLKDIV)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .reload (reload),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        reload    = 1'b0;
        txd_d     = 1'b1;

        last_stop = (state_q == ST_STOP) && (bit_cnt_q == LAST_STOP) && bit_end;
        fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || last_stop);

        case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[DWIDTH-1:1]};
                    reload  = 1'b1;
                    if (bit_cnt_q == LAST_DATA) begin
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        reload    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pop overrides the per-state transition: it either starts a frame
        // from idle or chains the next frame straight after the last stop bit.
        if (fifo_pop) begin
            shift_d   = fifo_data;
            par_d     = parity_bit(9'(fifo_data), PARITY);
            state_d   = ST_START;
            bit_cnt_d = '0;
            reload    = 1'b1;
        end

        // txd is registered from the next state so the line changes on the
        // same edge the FSM enters each bit.
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = par_d;
            default:   txd_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule
